load_store_unit: RTL and testbench

- Memory-stage consumer of the execute stage result: takes AluResult as the effective address, plus Func3 and the rs2 store data.
- Issues a single outstanding word-aligned request on a valid/ready data-memory port with byte strobes.
- Returns load data, aligned and sign/zero-extended, to writeback.
- Sequences misalignment, illegal-size and bus-timeout faults.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding word-aligned request on a
// valid/ready data port, load alignment/extension, and fault sequencing.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_st_done,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic [31:0] o_fault_addr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_FAULT} state_e;

  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_MISAL   = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    func3_q, func3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ldata_q, ldata_d;
  logic [1:0]    cause_q, cause_d;

  logic        accept;
  logic        func3_legal;
  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] rd_shifted;
  logic [31:0] ld_fmt;
  logic [3:0]  wstrb_fmt;
  logic [31:0] wdata_fmt;

  assign accept      = i_valid && (state_q == S_IDLE);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // Acceptance checks operate on the live inputs, before capture.
  always_comb begin
    func3_legal = 1'b0;
    if (i_we) func3_legal = (i_func3 == 3'd0) || (i_func3 == 3'd1) || (i_func3 == 3'd2);
    else      func3_legal = (i_func3 == 3'd0) || (i_func3 == 3'd1) || (i_func3 == 3'd2) ||
                            (i_func3 == 3'd4) || (i_func3 == 3'd5);
    misaligned = ((i_func3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_func3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  end

  // Load data: move the addressed byte lane to bit 0, then extend.
  always_comb begin
    rd_shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'd0:    ld_fmt = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'd4:    ld_fmt = {24'd0, rd_shifted[7:0]};
      3'd1:    ld_fmt = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'd5:    ld_fmt = {16'd0, rd_shifted[15:0]};
      default: ld_fmt = rd_shifted;
    endcase
  end

  // Store data is replicated across lanes so the strobes pick the right copy.
  always_comb begin
    case (func3_q[1:0])
      2'b00: begin
        wstrb_fmt = 4'b0001 << addr_q[1:0];
        wdata_fmt = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wstrb_fmt = 4'b0011 << addr_q[1:0];
        wdata_fmt = {2{wdata_q[15:0]}};
      end
      default: begin
        wstrb_fmt = 4'b1111;
        wdata_fmt = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    func3_d = func3_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ldata_d = ldata_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = i_addr;
          we_d    = i_we;
          func3_d = i_func3;
          wdata_d = i_wdata;
          rd_d    = i_rd;
          if (!func3_legal) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_FAULT;
          end else if (misaligned) begin
            cause_d = CAUSE_MISAL;
            state_d = S_FAULT;
          end else begin
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_ready) begin
          cnt_d   = '0;
          state_d = we_q ? S_RESP : S_WAIT;
        end else if (timeout_hit) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_rvalid) begin
          ldata_d = ld_fmt;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ldata_q <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ldata_q <= ldata_d;
      cause_q <= cause_d;
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_mem_valid   = (state_q == S_REQ);
  assign o_mem_addr    = {addr_q[31:2], 2'b00};
  assign o_mem_we      = (state_q == S_REQ) && we_q;
  assign o_mem_wstrb   = ((state_q == S_REQ) && we_q) ? wstrb_fmt : 4'd0;
  assign o_mem_wdata   = (state_q == S_REQ) ? wdata_fmt : 32'd0;
  assign o_wb_valid    = (state_q == S_RESP) && !we_q;
  assign o_wb_rd       = rd_q;
  assign o_wb_data     = ldata_q;
  assign o_st_done     = (state_q == S_RESP) && we_q;
  assign o_fault       = (state_q == S_FAULT);
  assign o_fault_cause = cause_q;
  assign o_fault_addr  = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short bus timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, we, mem_ready, mem_rvalid;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [4:0]  rd;
  logic        ready, mem_valid, mem_we, wb_valid, st_done, fault;
  logic [31:0] mem_addr, mem_wdata, wb_data, fault_addr;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .o_ready(ready), .i_we(we), .i_func3(func3),
    .i_addr(addr), .i_wdata(wdata), .i_rd(rd),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_we(mem_we), .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_st_done(st_done), .o_fault(fault), .o_fault_cause(fault_cause),
    .o_fault_addr(fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    valid = 1'b1; we = w; func3 = f3; addr = a; wdata = d; rd = r;
    tick();
    valid = 1'b0;
  endtask

  // Load with immediate handshake and rvalid in the first WAIT cycle.
  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdat, input logic [4:0] r,
                          input logic [31:0] exp);
    mem_ready = 1'b1;
    offer(1'b0, f3, a, 32'd0, r);
    chk({tag, "_req_valid"}, {31'd0, mem_valid}, 32'd1);
    chk({tag, "_req_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdat;
    tick();
    mem_ready = 1'b0;
    chk({tag, "_wait_valid"}, {31'd0, mem_valid}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
    tick();
    chk({tag, "_idle"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; we = 1'b0; func3 = 3'd0; addr = '0; wdata = '0; rd = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    tick(); tick();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SB at 0x1002, ready immediately: done two cycles after accept
    mem_ready = 1'b1;
    offer(1'b1, 3'd0, 32'h0000_1002, 32'h0000_00A5, 5'd0);
    chk("sb_valid", {31'd0, mem_valid}, 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h4);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_we", {31'd0, mem_we}, 32'd1);
    chk("sb_ready_busy", {31'd0, ready}, 32'd0);
    tick();
    mem_ready = 1'b0;
    chk("sb_done", {31'd0, st_done}, 32'd1);
    chk("sb_done_valid", {31'd0, mem_valid}, 32'd0);
    tick();
    chk("sb_done_pulse", {31'd0, st_done}, 32'd0);
    chk("sb_idle", {31'd0, ready}, 32'd1);

    load_chk("lb",  3'd0, 32'h0000_2003, 32'h80FF_1234, 5'd7,  32'hFFFF_FF80);
    load_chk("lbu", 3'd4, 32'h0000_2003, 32'h80FF_1234, 5'd9,  32'h0000_0080);
    load_chk("lh",  3'd1, 32'h0000_2002, 32'h80FF_1234, 5'd11, 32'hFFFF_80FF);
    load_chk("lhu", 3'd5, 32'h0000_2002, 32'h80FF_1234, 5'd12, 32'h0000_80FF);
    load_chk("lw",  3'd2, 32'h0000_2000, 32'h80FF_1234, 5'd31, 32'h80FF_1234);

    // Misaligned LW
    offer(1'b0, 3'd2, 32'h0000_3002, 32'd0, 5'd1);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_cause", {30'd0, fault_cause}, 32'd1);
    chk("mis_addr", fault_addr, 32'h0000_3002);
    chk("mis_no_req", {31'd0, mem_valid}, 32'd0);
    tick();
    chk("mis_pulse", {31'd0, fault}, 32'd0);
    chk("mis_no_req2", {31'd0, mem_valid}, 32'd0);
    chk("mis_idle", {31'd0, ready}, 32'd1);

    // Illegal load func3=3, aligned address
    offer(1'b0, 3'd3, 32'h0000_3000, 32'd0, 5'd1);
    chk("ill_fault", {31'd0, fault}, 32'd1);
    chk("ill_cause", {30'd0, fault_cause}, 32'd2);
    tick();

    // Illegal store func3=5 on an odd address: illegal wins over misaligned
    offer(1'b1, 3'd5, 32'h0000_3001, 32'd0, 5'd1);
    chk("ill_st_cause", {30'd0, fault_cause}, 32'd2);
    chk("ill_st_fault", {31'd0, fault}, 32'd1);
    tick();

    // SW with ready held low three cycles
    offer(1'b1, 3'd2, 32'h0000_4000, 32'hDEAD_BEEF, 5'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, mem_valid}, 32'd1);
      chk("stall_addr", mem_addr, 32'h0000_4000);
      chk("stall_wstrb", {28'd0, mem_wstrb}, 32'hF);
      chk("stall_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("stall_done", {31'd0, st_done}, 32'd0);
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    chk("stall_st_done", {31'd0, st_done}, 32'd1);
    chk("stall_valid_off", {31'd0, mem_valid}, 32'd0);
    tick();
    chk("stall_single", {31'd0, st_done}, 32'd0);
    chk("stall_idle", {31'd0, ready}, 32'd1);

    // SH at 0x5002 with ready never asserted: timeout after 4 REQ cycles
    offer(1'b1, 3'd1, 32'h0000_5002, 32'h1234_5678, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_valid", {31'd0, mem_valid}, 32'd1);
      chk("to_wstrb", {28'd0, mem_wstrb}, 32'hC);
      chk("to_wdata", mem_wdata, 32'h5678_5678);
      chk("to_no_fault", {31'd0, fault}, 32'd0);
      tick();
    end
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_cause", {30'd0, fault_cause}, 32'd3);
    chk("to_addr", fault_addr, 32'h0000_5002);
    chk("to_valid_off", {31'd0, mem_valid}, 32'd0);
    tick();
    chk("to_ready", {31'd0, ready}, 32'd1);
    chk("to_pulse", {31'd0, fault}, 32'd0);

    // Reset while waiting for load data; later stale rvalid is ignored
    mem_ready = 1'b1;
    offer(1'b0, 3'd2, 32'h0000_6000, 32'd0, 5'd3);
    tick();
    mem_ready = 1'b0;
    chk("rw_wait_ready", {31'd0, ready}, 32'd0);
    chk("rw_wait_valid", {31'd0, mem_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_ready_now", {31'd0, ready}, 32'd1);
    chk("rw_valid_now", {31'd0, mem_valid}, 32'd0);
    #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("rw_idle", {31'd0, ready}, 32'd1);
    end
    mem_rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
